// File: rtl/neighbor_pair_scheduler.sv
// rtl/neighbor_pair_scheduler.sv - streams particle pairs through calc_distance and emits neighbours closer than H
// Define SCHED_FULL_MATRIX_EN to sweep every ordered pair (i,j), j != i, instead of the upper triangle i<j.
module neighbor_pair_scheduler #(
    parameter int          N_PART    = 64,
    parameter int          DIMS      = 2,
    parameter logic [15:0] H         = 16'h4400,
    parameter int          MEM_LAT   = 2,
    parameter int          TAG_DEPTH = 32,
    localparam int         ADDR_W    = (N_PART > 1) ? $clog2(N_PART) : 1,
    localparam int         PW        = 16 * DIMS
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] pos_addr,
    output logic              pos_rd,
    input  logic [PW-1:0]     pos_rdata,
    output logic [PW-1:0]     dist_r_i,
    output logic [PW-1:0]     dist_r_j,
    output logic              dist_valid,
    input  logic [15:0]       dist_result,
    input  logic              dist_done,
    output logic              pair_valid,
    output logic [ADDR_W-1:0] pair_i,
    output logic [ADDR_W-1:0] pair_j,
    output logic [15:0]       pair_dist
);
`ifdef SCHED_FULL_MATRIX_EN
    localparam bit FULL = 1'b1;
`else
    localparam bit FULL = 1'b0;
`endif
    localparam int                PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int                CNT_W  = $clog2(TAG_DEPTH + 1);
    localparam logic [ADDR_W-1:0] I_LAST = ADDR_W'(FULL ? N_PART - 1 : N_PART - 2);
    localparam logic [ADDR_W:0]   N_END  = (ADDR_W + 1)'(N_PART);

    typedef enum logic [2:0] {S_IDLE, S_FETCH_I, S_WAIT_I, S_ISSUE, S_WAIT_J, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d, j_q, j_d;
    logic [PW-1:0]     r_i_q;
    logic              err_q;
    // one entry per position read in flight; isi marks the r_i fetch rather than a pair
    logic [MEM_LAT-1:0] ln_v_q, ln_isi_q;
    logic [ADDR_W-1:0]  ln_i_q [MEM_LAT];
    logic [ADDR_W-1:0]  ln_j_q [MEM_LAT];
    logic [ADDR_W-1:0]  fifo_i_q [TAG_DEPTH];
    logic [ADDR_W-1:0]  fifo_j_q [TAG_DEPTH];
    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               pair_valid_q;
    logic [ADDR_W-1:0]  pair_i_q, pair_j_q;
    logic [15:0]        pair_dist_q;

    logic              issue_rd, issue_isi, err_clr, line_busy, j_last;
    logic              tail_v, tail_isi, push, pop_ok, below_h;
    logic [ADDR_W-1:0] rd_addr, first_j;
    logic [ADDR_W:0]   j_inc;
    logic [31:0]       in_flight;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign tail_v   = ln_v_q[MEM_LAT-1];
    assign tail_isi = ln_isi_q[MEM_LAT-1];
    assign push     = tail_v & ~tail_isi;
    assign pop_ok   = dist_done & (cnt_q != '0);
    // sign bit ignored; Inf/NaN rejected even though H would already exclude them
    assign below_h  = (dist_result[14:10] != 5'h1F) && (dist_result[14:0] < H[14:0]);

    always_comb begin
        line_busy = 1'b0;
        in_flight = 32'(cnt_q);
        for (int k = 0; k < MEM_LAT; k++) begin
            line_busy = line_busy | ln_v_q[k];
            if (ln_v_q[k] && !ln_isi_q[k]) in_flight = in_flight + 32'd1;
        end
    end

    always_comb begin
        j_inc = {1'b0, j_q} + 1'b1;
        if (FULL && j_inc == {1'b0, i_q}) j_inc = j_inc + 1'b1;
        j_last = (j_inc >= N_END);
        if (FULL) first_j = (i_q == '0) ? ADDR_W'(1) : '0;
        else      first_j = i_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        issue_rd  = 1'b0;
        issue_isi = 1'b0;
        rd_addr   = '0;
        err_clr   = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                err_clr = 1'b1;
                i_d     = '0;
                state_d = (N_PART < 2) ? S_DRAIN : S_FETCH_I;
            end
            S_FETCH_I: begin
                issue_rd  = 1'b1;
                issue_isi = 1'b1;
                rd_addr   = i_q;
                state_d   = S_WAIT_I;
            end
            S_WAIT_I: if (tail_v && tail_isi) begin
                j_d     = first_j;
                state_d = S_ISSUE;
            end
            S_ISSUE: if (in_flight < 32'(TAG_DEPTH)) begin
                issue_rd = 1'b1;
                rd_addr  = j_q;
                if (j_last) state_d = S_WAIT_J;
                else        j_d     = j_inc[ADDR_W-1:0];
            end
            S_WAIT_J: if (!line_busy) begin
                if (i_q < I_LAST) begin
                    i_d     = i_q + 1'b1;
                    state_d = S_FETCH_I;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (cnt_q == '0 && !line_busy) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            i_q          <= '0;
            j_q          <= '0;
            r_i_q        <= '0;
            err_q        <= 1'b0;
            ln_v_q       <= '0;
            ln_isi_q     <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            pair_valid_q <= 1'b0;
            pair_i_q     <= '0;
            pair_j_q     <= '0;
            pair_dist_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            for (int k = MEM_LAT - 1; k > 0; k--) begin
                ln_v_q[k]   <= ln_v_q[k-1];
                ln_isi_q[k] <= ln_isi_q[k-1];
            end
            ln_v_q[0]   <= issue_rd;
            ln_isi_q[0] <= issue_isi;
            if (tail_v && tail_isi) r_i_q <= pos_rdata;
            if (push)   wptr_q <= ptr_next(wptr_q);
            if (pop_ok) rptr_q <= ptr_next(rptr_q);
            if (push && !pop_ok)      cnt_q <= cnt_q + 1'b1;
            else if (pop_ok && !push) cnt_q <= cnt_q - 1'b1;
            if (err_clr) err_q <= 1'b0;
            if (dist_done && cnt_q == '0) err_q <= 1'b1;
            pair_valid_q <= pop_ok && below_h;
            if (pop_ok) begin
                pair_i_q    <= fifo_i_q[rptr_q];
                pair_j_q    <= fifo_j_q[rptr_q];
                pair_dist_q <= dist_result;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        for (int k = MEM_LAT - 1; k > 0; k--) begin
            ln_i_q[k] <= ln_i_q[k-1];
            ln_j_q[k] <= ln_j_q[k-1];
        end
        ln_i_q[0] <= i_q;
        ln_j_q[0] <= rd_addr;
        if (push) begin
            fifo_i_q[wptr_q] <= ln_i_q[MEM_LAT-1];
            fifo_j_q[wptr_q] <= ln_j_q[MEM_LAT-1];
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign pos_rd     = issue_rd;
    assign pos_addr   = rd_addr;
    assign dist_valid = push;
    assign dist_r_i   = push ? r_i_q : '0;
    assign dist_r_j   = push ? pos_rdata : '0;
    assign pair_valid = pair_valid_q;
    assign pair_i     = pair_i_q;
    assign pair_j     = pair_j_q;
    assign pair_dist  = pair_dist_q;

endmodule

// File: tb/tb_neighbor_pair_scheduler.sv
// tb/tb_neighbor_pair_scheduler.sv - bench for neighbor_pair_scheduler with position RAM and distance-unit models
module tb_neighbor_pair_scheduler;
    localparam int          N    = 6;
    localparam int          AW   = 3;
    localparam int          ML   = 2;
    localparam int          TD   = 4;
    localparam int          DLAT = 12;
    localparam logic [15:0] H    = 16'h4400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, inj;
    logic          busy, done, err, pos_rd, dist_valid, dist_done, pair_valid;
    logic [AW-1:0] pos_addr, pair_i, pair_j;
    logic [31:0]   pos_rdata, dist_r_i, dist_r_j;
    logic [15:0]   dist_result, pair_dist;

    logic          start1, busy1, done1, err1, pos_rd1, dist_valid1, pair_valid1, dist_done1;
    logic [0:0]    pos_addr1, pair_i1, pair_j1;
    logic [31:0]   pos_rdata1, dist_r_i1, dist_r_j1;
    logic [15:0]   dist_result1, pair_dist1;

    neighbor_pair_scheduler #(.N_PART(N), .DIMS(2), .H(H), .MEM_LAT(ML), .TAG_DEPTH(TD)) dut (
        .clk_in(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .pos_addr(pos_addr), .pos_rd(pos_rd), .pos_rdata(pos_rdata),
        .dist_r_i(dist_r_i), .dist_r_j(dist_r_j), .dist_valid(dist_valid),
        .dist_result(dist_result), .dist_done(dist_done),
        .pair_valid(pair_valid), .pair_i(pair_i), .pair_j(pair_j), .pair_dist(pair_dist));

    neighbor_pair_scheduler #(.N_PART(1), .DIMS(2), .H(H), .MEM_LAT(ML), .TAG_DEPTH(TD)) dut1 (
        .clk_in(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .err(err1),
        .pos_addr(pos_addr1), .pos_rd(pos_rd1), .pos_rdata(pos_rdata1),
        .dist_r_i(dist_r_i1), .dist_r_j(dist_r_j1), .dist_valid(dist_valid1),
        .dist_result(dist_result1), .dist_done(dist_done1),
        .pair_valid(pair_valid1), .pair_i(pair_i1), .pair_j(pair_j1), .pair_dist(pair_dist1));

    int vectors = 0;
    int miscompares = 0;

    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) for (int n = 0; n < k; n++) r = r * 2.0;
        else        for (int n = 0; n < -k; n++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real v;
        if (h[14:10] == 5'd0) v = real'(h[9:0]) * pow2(-24);
        else                  v = (1.0 + real'(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2h(input real x);
        real v;
        int  e, m;
        if (x <= 0.0) return 16'h0000;
        if (x >= 65504.0) return 16'h7C00;
        v = x;
        e = 15;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0 && e > 1) begin v = v * 2.0; e--; end
        if (v < 1.0) begin
            m = $rtoi(v * 1024.0);
            return {6'b0, m[9:0]};
        end
        m = $rtoi((v - 1.0) * 1024.0);
        return {1'b0, e[4:0], m[9:0]};
    endfunction

    function automatic logic [15:0] dist_of(input logic [31:0] a, input logic [31:0] b);
        real dx, dy;
        dx = h2r(a[15:0]) - h2r(b[15:0]);
        dy = h2r(a[31:16]) - h2r(b[31:16]);
        return r2h($sqrt(dx * dx + dy * dy));
    endfunction

    function automatic logic [31:0] xy(input real x, input real y);
        return {r2h(y), r2h(x)};
    endfunction

    // position RAM, two-cycle read latency
    logic [31:0]   mem [8];
    logic [AW-1:0] ra;
    always @(posedge clk) begin
        ra        <= pos_addr;
        pos_rdata <= mem[ra];
    end

    // calc_distance stand-in: fixed-latency pipeline, reset along with the scheduler
    logic [DLAT-1:0] dv;
    logic [15:0]     dr [DLAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv <= '0;
        end else begin
            dv    <= {dv[DLAT-2:0], dist_valid};
            dr[0] <= dist_of(dist_r_i, dist_r_j);
            for (int k = 1; k < DLAT; k++) dr[k] <= dr[k-1];
        end
    end
    assign dist_done   = dv[DLAT-1] | inj;
    assign dist_result = dr[DLAT-1];

    logic [31:0] got_ri[$], got_rj[$];
    logic [21:0] got_pair[$];
    logic [5:0]  exp_ij[$];
    logic [21:0] exp_pair[$];
    int done_cnt, inflight, max_inflight, done1_cnt, dv1_cnt;

    always @(negedge clk) begin
        if (dist_valid) begin
            got_ri.push_back(dist_r_i);
            got_rj.push_back(dist_r_j);
        end
        if (pair_valid) got_pair.push_back({pair_i, pair_j, pair_dist});
        if (done) done_cnt++;
        if (done1) done1_cnt++;
        if (dist_valid1) dv1_cnt++;
        if (!rst_n) inflight = 0;
        else if (busy) inflight = inflight + int'(dist_valid) - int'(dist_done);
        if (inflight > max_inflight) max_inflight = inflight;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic zero_check(input string tag);
        check({tag, "_ctl"}, {busy, done, err, pos_rd, dist_valid, pair_valid}, 64'd0);
        check({tag, "_idx"}, {pos_addr, pair_i, pair_j, pair_dist}, 64'd0);
        check({tag, "_r"}, {dist_r_i, dist_r_j}, 64'd0);
    endtask

    // reference: enumerate pairs in issue order and keep those whose distance is strictly below H
    task automatic build_expect();
        logic [15:0] hv;
        exp_ij.delete();
        exp_pair.delete();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == i) continue;
`ifndef SCHED_FULL_MATRIX_EN
                if (j < i) continue;
`endif
                exp_ij.push_back({3'(i), 3'(j)});
                hv = dist_of(mem[i], mem[j]);
                if (hv[14:0] < H[14:0]) exp_pair.push_back({3'(i), 3'(j), hv});
            end
        end
    endtask

    task automatic run_pass(input string tag, input bit poke);
        int cyc;
        build_expect();
        got_ri.delete();
        got_rj.delete();
        got_pair.delete();
        done_cnt     = 0;
        max_inflight = 0;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_errclr"}, err, 0);
        cyc = 0;
        while (done_cnt == 0 && cyc < 4000) begin
            @(negedge clk); #1;
            cyc++;
            start = poke && (cyc == 6 || cyc == 30);
        end
        start = 1'b0;
        check({tag, "_done"}, done_cnt, 1);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_credit"}, max_inflight <= TD, 1);
        check({tag, "_niss"}, got_ri.size(), exp_ij.size());
        for (int k = 0; k < exp_ij.size() && k < got_ri.size(); k++)
            check($sformatf("%s_iss%0d", tag, k), {got_ri[k], got_rj[k]},
                  {mem[exp_ij[k][5:3]], mem[exp_ij[k][2:0]]});
        check({tag, "_npair"}, got_pair.size(), exp_pair.size());
        for (int k = 0; k < exp_pair.size() && k < got_pair.size(); k++)
            check($sformatf("%s_pair%0d", tag, k), got_pair[k], exp_pair[k]);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; start = 1'b0; inj = 1'b0;
        start1 = 1'b0; pos_rdata1 = '0; dist_result1 = '0; dist_done1 = 1'b0;
        for (int k = 0; k < 8; k++) mem[k] = '0;
        repeat (3) @(negedge clk);
        #1;
        zero_check("reset");
        check("reset_dut1", {busy1, done1, err1, pos_rd1, dist_valid1, pair_valid1}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        mem[0] = xy(0, 0); mem[1] = xy(1, 0); mem[2] = xy(0, 3);
        mem[3] = xy(5, 5); mem[4] = xy(100, 0); mem[5] = xy(0, 100);
        run_pass("t1", 1'b0);
`ifdef SCHED_FULL_MATRIX_EN
        check("t1_pairs_full", got_pair.size(), 6);
`else
        check("t1_pairs", got_pair.size(), 3);
`endif

        mem[0] = xy(0, 0); mem[1] = xy(4, 0); mem[2] = xy(40, 0);
        mem[3] = xy(0, 40); mem[4] = xy(40, 40); mem[5] = xy(80, 80);
        run_pass("t2_equal_h", 1'b0);
        check("t2_no_pair", got_pair.size(), 0);

        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < N; k++)
                mem[k] = {r2h(real'($urandom_range(0, 24)) / 4.0), r2h(real'($urandom_range(0, 24)) / 4.0)};
            run_pass($sformatf("rnd%0d", p), p == 1);
        end

        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (got_ri.size() < 3 && cyc < 500) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("t5_reached_issue", got_ri.size() >= 3, 1);
        rst_n = 1'b0;
        #1;
        zero_check("t5_midreset");
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        run_pass("t5_restart", 1'b0);

        got_pair.delete();
        inj = 1'b1;
        @(negedge clk); #1;
        inj = 1'b0;
        check("t6_spur_err", err, 1);
        repeat (4) @(negedge clk);
        #1;
        check("t6_spur_hold", err, 1);
        check("t6_spur_nopair", got_pair.size(), 0);
        run_pass("t6_after_spur", 1'b0);

        done1_cnt = 0;
        dv1_cnt   = 0;
        start1 = 1'b1;
        @(negedge clk); #1;
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("t4_n1_done", done1_cnt, 1);
        check("t4_n1_nodist", dv1_cnt, 0);
        check("t4_n1_idle", busy1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
